odu_frame_gen: RTL and testbench
================================

// Module: odu_frame_gen
// PURPOSE
//  Parametrised ODU frame generator; the successor of the fixed 4-row/80-beat ODU data generator.
//  Takes a streaming payload (packed OSU bytes) on a valid/ready input and maps it into ODU rows.
//  Each row gets a programmable per-row overhead, an optional MFAS byte and optional end-of-row stuffing.
//  A byte gearbox absorbs the misalignment these insertions cause. Sits between the OSU mapper and the OTU framer.
// PARAMETERS
//  DATA_W      384    bus width in bits; BEAT_B = DATA_W/8 bytes per beat
//  OH_BYTES    16     overhead bytes at the start of every row; 1 <= OH_BYTES < BEAT_B
//  STUFF_BYTES 16     stuff bytes at the end of every row when stuff_en=1; 0 <= STUFF_BYTES < BEAT_B
//  ROW_BEATS   80     beats per row; >= 2
//  ROWS        4      rows per frame; >= 1
//  STUFF_BYTE  8'h99  stuff byte value
//  MFAS_EN     1      1: overhead byte MFAS_POS of row 0 is replaced by the MFAS counter
//  MFAS_POS    6      byte index of MFAS within the row-0 overhead; < OH_BYTES
// PORTS
//  clk          in   1                     clock
//  rst_n        in   1                     asynchronous reset, active low
//  enable       in   1                     run request; sampled at frame boundaries only
//  stuff_en     in   1                     enable end-of-row stuffing; sampled at row start
//  oh_in        in   ROWS*OH_BYTES*8       overhead per row; row 0 in the MSBs, byte 0 of each row first
//  in_data      in   DATA_W                payload word; byte 0 in [DATA_W-1 -: 8]
//  in_valid     in   1                     in_data valid
//  in_ready     out  1                     in_data accepted when in_valid & in_ready
//  out_data     out  DATA_W                ODU beat; byte 0 in the MSBs
//  out_valid    out  1                     out_data valid; held until out_ready
//  out_ready    in   1                     downstream accept
//  frame_start  out  1                     qualifies out_data: beat 0 of row 0
//  row_start    out  1                     qualifies out_data: beat 0 of any row, including row 0
//  mfas         out  8                     MFAS value of the current or most recent frame
//  busy         out  1                     state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - out_data=0, out_valid=0, frame_start=0, row_start=0, mfas=0, busy=0, in_ready=0.
//   - Residue emptied; row and beat counters 0; state IDLE.
//   - A reset asserted mid-frame discards the partial frame. The first frame after reset starts at row 0 / beat 0.
//  State machine:
//   - IDLE -> RUN when enable=1. in_ready=0 in IDLE.
//   - RUN  -> DRAIN when enable=0 is seen before the frame is complete. The current frame always completes.
//   - At a frame boundary (last beat of row ROWS-1 accepted downstream): RUN/DRAIN -> RUN if enable=1, else IDLE.
//   - Residue bytes are kept across IDLE and are emitted first in the next frame.
//  Beat composition (row r, beat b):
//   - b=0: OH_BYTES bytes from row r of oh_in, then payload. With MFAS_EN, row 0 byte MFAS_POS = mfas.
//   - b=ROW_BEATS-1 with stuff_en latched=1: payload, then STUFF_BYTES x STUFF_BYTE at the LSB end.
//   - All other beats: BEAT_B payload bytes.
//   - If ROW_BEATS=2, both insertions apply to their own beats.
//  Gearbox:
//   - Residue buffer is 2*BEAT_B bytes wide with a byte count cnt.
//   - in_ready = (state != IDLE) & (cnt <= BEAT_B).
//   - An output beat is built only when cnt covers the payload bytes it needs (or cnt+BEAT_B with a same-cycle accept).
//   - Accept and consume may occur in the same cycle; cnt is updated with both.
//   - Payload bytes are emitted in strict arrival order with no loss, duplication or idle bubbles inside the frame content.
//   - Underrun: out_valid stays 0 (a gap in time only); counters do not advance.
//  Output handshake:
//   - Registered output. A new beat is loaded when !out_valid | out_ready.
//   - out_data, frame_start and row_start are held stable while out_valid & !out_ready.
//   - Latency: a word accepted in cycle t can appear on out_valid at t+1 at the earliest.
//  Counters:
//   - Beat counter wraps ROW_BEATS-1 -> 0 and then increments row.
//   - Row counter wraps ROWS-1 -> 0.
//   - mfas increments by 1 when the last beat of a frame is accepted; 8'hFF -> 8'h00.
//  Static configuration:
//   - oh_in is sampled when beat 0 of a row is built.
//   - Parameter constraints are checked by elaboration-time assertions.
// TESTING
//  T1 defaults, stuff_en=1, oh row r = {16{r+1 replicated in both nibbles}}, payload bytes 00,01,02.. ->
//     row0 beat0 = 11..11 except byte6 = 00 (MFAS), then 00..1F; frame_start=1, row_start=1.
//  T2 same stimulus -> row0 beat79 = 32 payload bytes, then 16 x 99.
//     row1 beat0 = 22x16 followed by E0,E1.. (3808 payload bytes per row); row_start=1, frame_start=0.
//  T3 stuff_en=0 -> 3824 payload bytes per row. Row1 beat0 payload starts at F0. Beat79 carries no 99 bytes.
//  T4 random out_ready (50%) and random in_valid gaps over 3 frames ->
//     byte stream equals the reference model; out_data is stable while stalled; mfas reads 00,01,02.
//  T5 enable dropped at row1 beat10 -> frame completes through row3 beat79; then IDLE, busy=0, in_ready=0.
//     Re-enable -> next frame carries mfas=01 and payload continues without gap.
//  T6 rst_n pulsed low at row2 beat40 -> all outputs 0 immediately.
//     After release + enable, the frame starts at row0 with mfas=00.

Source files
------------

// File: rtl/odu_frame_gen.sv
// ODU frame generator: maps a packed payload stream into ODU rows with per-row overhead,
// an optional MFAS byte and optional end-of-row stuffing, using a byte gearbox.
module odu_frame_gen #(
  parameter int unsigned DATA_W      = 384,
  parameter int unsigned OH_BYTES    = 16,
  parameter int unsigned STUFF_BYTES = 16,
  parameter int unsigned ROW_BEATS   = 80,
  parameter int unsigned ROWS        = 4,
  parameter logic [7:0]  STUFF_BYTE  = 8'h99,
  parameter bit          MFAS_EN     = 1'b1,
  parameter int unsigned MFAS_POS    = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         stuff_en,
  input  logic [ROWS*OH_BYTES*8-1:0]   oh_in,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_start,
  output logic                         row_start,
  output logic [7:0]                   mfas,
  output logic                         busy
);

  localparam int unsigned BeatB = DATA_W / 8;
  localparam int unsigned ResB  = 2 * BeatB;
  localparam int unsigned ResW  = ResB * 8;
  localparam int unsigned OhW   = ROWS * OH_BYTES * 8;
  localparam int unsigned CntW  = $clog2(ResB + 1);
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BeatW = $clog2(ROW_BEATS);

  if (DATA_W % 8 != 0 || OH_BYTES < 1 || OH_BYTES >= BeatB || STUFF_BYTES >= BeatB ||
      ROW_BEATS < 2 || ROWS < 1 || MFAS_POS >= OH_BYTES) begin : g_bad_params
    $error("odu_frame_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e              state_q;
  logic [RowW-1:0]     row_q;
  logic [BeatW-1:0]    beat_q;
  logic                stuff_q;
  logic [CntW-1:0]     cnt_q;
  logic [ResW-1:0]     res_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                frame_start_q;
  logic                row_start_q;
  logic                last_q;
  logic [7:0]          mfas_q;

  logic                accept, load, last_fire, build;
  logic                first_beat, last_beat, frame_last, stuff_now;
  logic [CntW-1:0]     need, avail, cnt_d;
  logic [ResW-1:0]     comb, ext, res_d;
  logic [DATA_W-1:0]   beat_data;
  logic [7:0]          mfas_cur;

  assign in_ready    = (state_q != StIdle) && (cnt_q <= CntW'(BeatB));
  assign busy        = (state_q != StIdle);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign row_start   = row_start_q;
  assign mfas        = mfas_q;

  assign accept     = in_valid & in_ready;
  assign load       = ~out_valid_q | out_ready;
  assign last_fire  = out_valid_q & out_ready & last_q;
  assign first_beat = (beat_q == '0);
  assign last_beat  = (beat_q == BeatW'(ROW_BEATS - 1));
  assign frame_last = last_beat && (row_q == RowW'(ROWS - 1));
  assign stuff_now  = last_beat & stuff_q;
  // The beat built alongside the frame's final handshake already belongs to the next frame.
  assign mfas_cur   = last_fire ? mfas_q + 8'd1 : mfas_q;

  always_comb begin
    int unsigned oh_off;
    int unsigned st_off;
    logic [7:0]  byte_v;
    oh_off    = first_beat ? OH_BYTES : 0;
    st_off    = stuff_now ? STUFF_BYTES : 0;
    need      = CntW'(BeatB - oh_off - st_off);
    avail     = cnt_q + (accept ? CntW'(BeatB) : '0);
    // New word lands directly behind the bytes already held in the residue.
    ext       = {in_data, {DATA_W{1'b0}}} >> {cnt_q, 3'b000};
    comb      = res_q | (accept ? ext : '0);
    build     = (state_q != StIdle) && load && (avail >= need) && (!last_q || enable);
    res_d     = build ? (comb << {need, 3'b000}) : comb;
    cnt_d     = build ? (avail - need) : avail;
    beat_data = '0;
    byte_v    = '0;
    for (int unsigned i = 0; i < BeatB; i++) begin
      if (i < oh_off) begin
        byte_v = oh_in[OhW - 1 - 8 * (int'(row_q) * OH_BYTES + i) -: 8];
        if (MFAS_EN && row_q == '0 && i == MFAS_POS) byte_v = mfas_cur;
      end else if (i >= BeatB - st_off) begin
        byte_v = STUFF_BYTE;
      end else begin
        byte_v = comb[ResW - 1 - 8 * (i - oh_off) -: 8];
      end
      beat_data[DATA_W - 1 - 8 * i -: 8] = byte_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      row_q         <= '0;
      beat_q        <= '0;
      stuff_q       <= 1'b0;
      cnt_q         <= '0;
      res_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      row_start_q   <= 1'b0;
      last_q        <= 1'b0;
      mfas_q        <= '0;
    end else begin
      res_q <= res_d;
      cnt_q <= cnt_d;
      if (build) begin
        out_data_q    <= beat_data;
        out_valid_q   <= 1'b1;
        frame_start_q <= first_beat && (row_q == '0);
        row_start_q   <= first_beat;
        last_q        <= frame_last;
        if (first_beat) stuff_q <= stuff_en;
        if (last_beat) begin
          beat_q <= '0;
          row_q  <= (row_q == RowW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end else if (load) begin
        out_valid_q   <= 1'b0;
        frame_start_q <= 1'b0;
        row_start_q   <= 1'b0;
        last_q        <= 1'b0;
      end
      if (last_fire) mfas_q <= mfas_q + 8'd1;
      unique case (state_q)
        StIdle:  if (enable) state_q <= StRun;
        StRun: begin
          if (last_fire)   state_q <= enable ? StRun : StIdle;
          else if (!enable) state_q <= StDrain;
        end
        StDrain: if (last_fire) state_q <= enable ? StRun : StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_odu_frame_gen.sv
// Randomized bench for odu_frame_gen against a byte-queue model of the ODU row layout.
module tb_odu_frame_gen;

  localparam int DW = 384;
  localparam int BB = 48;
  localparam int OH = 16;
  localparam int ST = 16;
  localparam int RB = 80;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              stuff_en = 1'b0;
  logic [NR*OH*8-1:0] oh_in = '0;
  logic [DW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              frame_start;
  logic              row_start;
  logic [7:0]        mfas;
  logic              busy;

  always #5 clk = ~clk;

  odu_frame_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .stuff_en    (stuff_en),
    .oh_in       (oh_in),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_start (frame_start),
    .row_start   (row_start),
    .mfas        (mfas),
    .busy        (busy)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  q[$];
  int          valid_pct = 100;
  int          ready_pct = 100;
  bit          seq_mode = 1'b1;
  int          seq_b = 0;
  bit          in_taken = 1'b0;
  bit          stalled = 1'b0;
  logic [DW-1:0] held;
  int          m_row = 0;
  int          m_beat = 0;
  int          m_frames = 0;
  logic [7:0]  m_mfas = 8'h00;
  logic [7:0]  oh_b [NR][OH];
  logic [DW-1:0] cap_r0b0, cap_r0b79, cap_r1b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] byte_of(input logic [DW-1:0] w, input int i);
    return w[DW-1-8*i -: 8];
  endfunction

  task automatic pack_oh();
    for (int r = 0; r < NR; r++)
      for (int j = 0; j < OH; j++) oh_in[NR*OH*8-1-8*(r*OH+j) -: 8] = oh_b[r][j];
  endtask

  // Expected beat from the row layout: overhead, payload in arrival order, trailing stuff.
  task automatic check_beat();
    logic [DW-1:0] exp;
    int oh_n, st_n;
    logic [7:0] b;
    oh_n = (m_beat == 0) ? OH : 0;
    st_n = (m_beat == RB-1 && stuff_en) ? ST : 0;
    for (int i = 0; i < BB; i++) begin
      if (i < oh_n) b = (m_row == 0 && i == 6) ? m_mfas : oh_b[m_row][i];
      else if (i >= BB - st_n) b = 8'h99;
      else if (q.size() > 0) b = q.pop_front();
      else b = 'x;
      exp[DW-1-8*i -: 8] = b;
    end
    check("beat_data", out_data, exp);
    check("frame_start", frame_start, (m_row == 0 && m_beat == 0));
    check("row_start", row_start, (m_beat == 0));
    if (m_row == 0 && m_beat == 0) check("mfas_out", mfas, m_mfas);
    if (m_row == 0 && m_beat == 0) cap_r0b0 = out_data;
    if (m_row == 0 && m_beat == RB-1) cap_r0b79 = out_data;
    if (m_row == 1 && m_beat == 0) cap_r1b0 = out_data;
    if (m_beat == RB-1) begin
      m_beat = 0;
      if (m_row == NR-1) begin
        m_row = 0;
        m_frames++;
        m_mfas = m_mfas + 8'd1;
      end else begin
        m_row++;
      end
    end else begin
      m_beat++;
    end
  endtask

  task automatic step();
    bit in_fire, out_fire;
    @(negedge clk);
    if (stalled) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, held);
    end
    if (in_taken) begin
      in_valid = 1'b0;
      in_taken = 1'b0;
    end
    if (!in_valid && $urandom_range(99) < valid_pct) begin
      in_valid = 1'b1;
      for (int i = 0; i < BB; i++)
        in_data[DW-1-8*i -: 8] = seq_mode ? 8'(seq_b + i) : 8'($urandom);
    end
    out_ready = ($urandom_range(99) < ready_pct);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire) check_beat();
    stalled = out_valid && !out_ready;
    held    = out_data;
    if (in_fire) begin
      for (int i = 0; i < BB; i++) q.push_back(byte_of(in_data, i));
      if (seq_mode) seq_b += BB;
      in_taken = 1'b1;
    end
  endtask

  task automatic wait_pos(input int f, input int r, input int b, input int budget,
                          input string tag);
    for (int n = 0; n < budget && !(m_frames == f && m_row == r && m_beat == b); n++) step();
    check(tag, (m_frames == f && m_row == r && m_beat == b), 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int n = 0; n < budget && busy; n++) step();
    check(tag, busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_frame_start"}, frame_start, 1'b0);
    check({tag, "_row_start"}, row_start, 1'b0);
    check({tag, "_mfas"}, mfas, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] t1;
    for (int r = 0; r < NR; r++)
      for (int j = 0; j < OH; j++) oh_b[r][j] = 8'((r + 1) * 17);
    pack_oh();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Full-rate sequential payload with stuffing; drop enable at row 1 beat 10.
    stuff_en = 1'b1;
    enable   = 1'b1;
    wait_pos(0, 1, 11, 2000, "reach_r1b10");
    for (int i = 0; i < BB; i++) t1[DW-1-8*i -: 8] = (i < OH) ? ((i == 6) ? 8'h00 : 8'h11) : 8'(i - OH);
    check("t1_row0_beat0", cap_r0b0, t1);
    check("t2_stuff_tail", cap_r0b79[16*8-1:0], {16{8'h99}});
    check("t2_beat79_first", byte_of(cap_r0b79, 0), 8'hC0);
    check("t2_row1_oh", cap_r1b0[DW-1 -: OH*8], {16{8'h22}});
    check("t2_row1_payload", byte_of(cap_r1b0, OH), 8'hE0);
    enable = 1'b0;
    wait_idle(2000, "t5_idle");
    check("t5_frames", m_frames, 1);
    check("t5_in_ready", in_ready, 1'b0);
    check("t5_out_valid", out_valid, 1'b0);

    // Second frame without stuffing, started from idle and drained immediately.
    stuff_en = 1'b0;
    enable   = 1'b1;
    wait_pos(1, 0, 1, 500, "t3_start");
    enable = 1'b0;
    wait_idle(2000, "t3_idle");
    check("t3_frames", m_frames, 2);
    check("t3_row_payload", 8'(byte_of(cap_r1b0, OH) - byte_of(cap_r0b0, OH)), 8'hF0);
    check("t5_mfas_byte", byte_of(cap_r0b0, 6), 8'h01);

    // Random traffic, then a mid-frame reset.
    stuff_en  = 1'b1;
    seq_mode  = 1'b0;
    valid_pct = 70;
    ready_pct = 50;
    enable    = 1'b1;
    wait_pos(2, 2, 41, 3000, "t6_reach");
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    q.delete();
    m_row = 0;
    m_beat = 0;
    m_frames = 0;
    m_mfas = 8'h00;
    stalled = 1'b0;
    in_valid = 1'b0;
    in_taken = 1'b0;
    enable = 1'b0;
    for (int r = 0; r < NR; r++)
      for (int j = 0; j < OH; j++) oh_b[r][j] = 8'($urandom);
    pack_oh();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_pos(3, 0, 0, 12000, "t4_three_frames");
    enable = 1'b0;
    wait_idle(3000, "t4_idle");
    check("t4_in_ready", in_ready, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
